// File: rtl/serial_tx_phy_pkg.sv
// Shared definitions for the serial line transmitter: FSM states, parity modes
// and the parity function reused by the matching receiver.
package serial_tx_phy_pkg;

    localparam int unsigned MaxDataBits = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    typedef enum logic [2:0] {
        ParNone,
        ParEven,
        ParOdd,
        ParMark,
        ParSpace
    } parity_e;

    // Word must be zero-extended so unused upper bits do not disturb the XOR.
    function automatic logic parity_bit(input parity_e mode,
                                        input logic [MaxDataBits-1:0] word);
        logic p;
        p = 1'b0;
        case (mode)
            ParEven:  p = ^word;
            ParOdd:   p = ~(^word);
            ParMark:  p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/serial_baud_strobe.sv
// Bit-time divider: counts DIVISOR clock cycles per line bit and flags the
// last cycle of each bit. A restart realigns the count to a fresh bit.
module serial_baud_strobe #(
    parameter int unsigned DIVISOR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIVISOR - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_end = (cnt_q == CntLast);

endmodule

// File: rtl/serial_tx_phy.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits, fed by a rdy/ack word handshake.
module serial_tx_phy
    import serial_tx_phy_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIVISOR   = 16,
    parameter string       PARITY    = "none",
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 ack,
    output logic                 rdy,
    output logic                 tx
);

    localparam parity_e Mode = (PARITY == "even")  ? ParEven  :
                               (PARITY == "odd")   ? ParOdd   :
                               (PARITY == "mark")  ? ParMark  :
                               (PARITY == "space") ? ParSpace : ParNone;
    localparam bit HasParity = (Mode != ParNone);
    localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           idx_q;
    logic                 par_q;
    logic                 tx_q;

    logic bit_end;
    logic last_stop;
    logic can_accept;
    logic accept;

    serial_baud_strobe #(
        .DIVISOR(DIVISOR)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .bit_end (bit_end)
    );

    assign last_stop  = (state_q == StStop) && (idx_q == StopLast) && bit_end;
    assign can_accept = (state_q == StIdle) || last_stop;
    assign accept     = ack && can_accept && !rst;
    assign rdy        = rst || can_accept;
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StStart;
                        shift_q <= data;
                        par_q   <= parity_bit(Mode, MaxDataBits'(data));
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (idx_q != DataLast) begin
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end else if (HasParity) begin
                            state_q <= StParity;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= StStop;
                            idx_q   <= '0;
                            tx_q    <= 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        idx_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (idx_q != StopLast) begin
                            idx_q <= idx_q + 1'b1;
                        end else if (accept) begin
                            // Back-to-back: next start bit follows with no idle gap.
                            state_q <= StStart;
                            shift_q <= data;
                            par_q   <= parity_bit(Mode, MaxDataBits'(data));
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_phy.sv
// Bench for serial_tx_phy: four configurations checked cycle by cycle against
// a frame model computed from bit positions.
module tb_serial_tx_phy;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] data_a [4];
    logic       ack_a  [4];
    logic       rdy_a  [4];
    logic       tx_a   [4];

    int passed = 0;
    int total  = 0;

    // Configurations; parity code: 0 none, 1 even, 2 odd, 3 mark, 4 space.
    int db_c   [4] = '{8, 8, 5, 8};
    int div_c  [4] = '{4, 1, 3, 4};
    int par_c  [4] = '{1, 0, 3, 2};
    int stop_c [4] = '{1, 2, 1, 1};

    always #5 clk = ~clk;

    serial_tx_phy #(.DATA_BITS(8), .DIVISOR(4), .PARITY("even"), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .data(data_a[0][7:0]), .ack(ack_a[0]), .rdy(rdy_a[0]),
        .tx(tx_a[0]));
    serial_tx_phy #(.DATA_BITS(8), .DIVISOR(1), .PARITY("none"), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .data(data_a[1][7:0]), .ack(ack_a[1]), .rdy(rdy_a[1]),
        .tx(tx_a[1]));
    serial_tx_phy #(.DATA_BITS(5), .DIVISOR(3), .PARITY("mark"), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .data(data_a[2][4:0]), .ack(ack_a[2]), .rdy(rdy_a[2]),
        .tx(tx_a[2]));
    serial_tx_phy #(.DATA_BITS(8), .DIVISOR(4), .PARITY("odd"), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .data(data_a[3][7:0]), .ack(ack_a[3]), .rdy(rdy_a[3]),
        .tx(tx_a[3]));

    function automatic int frame_len(input int k);
        return (1 + db_c[k] + ((par_c[k] != 0) ? 1 : 0) + stop_c[k]) * div_c[k];
    endfunction

    // Expected line level t cycles after the accept (t = 1 .. frame_len).
    function automatic logic model_tx(input int k, input logic [8:0] w, input int t);
        int b;
        int ones;
        b = (t - 1) / div_c[k];
        if (b == 0) return 1'b0;
        if (b <= db_c[k]) return w[b-1];
        if (par_c[k] != 0 && b == db_c[k] + 1) begin
            ones = 0;
            for (int i = 0; i < db_c[k]; i++) ones += int'(w[i]);
            case (par_c[k])
                1: return logic'(ones % 2);
                2: return logic'(1 - ones % 2);
                3: return 1'b1;
                default: return 1'b0;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("u%0d idle tx", k), tx_a[k], 1'b1);
            check($sformatf("u%0d idle rdy", k), rdy_a[k], 1'b1);
        end
    endtask

    // Called at a negedge in a cycle where unit k is ready. With hold, ack stays
    // high and nxt is offered in the last stop cycle. With mid, ack is pulsed
    // mid-frame with 0xFF and data keeps changing.
    task automatic send(input int k, input logic [8:0] w, input bit hold,
                        input logic [8:0] nxt, input bit mid);
        int f;
        f = frame_len(k);
        data_a[k] = w;
        ack_a[k]  = 1'b1;
        for (int t = 1; t <= f; t++) begin
            @(negedge clk);
            check($sformatf("u%0d w=%h t%0d tx", k, w, t), tx_a[k], model_tx(k, w, t));
            check($sformatf("u%0d w=%h t%0d rdy", k, w, t), rdy_a[k], logic'(t == f));
            if (t == 1 && !hold) ack_a[k] = 1'b0;
            if (mid) begin
                if (t == f / 2) begin
                    ack_a[k]  = 1'b1;
                    data_a[k] = 9'h0FF;
                end else begin
                    ack_a[k] = 1'b0;
                    if (t > 1 && t < f) data_a[k] = 9'($urandom);
                end
            end
            if (t == f && hold) data_a[k] = nxt;
        end
    endtask

    initial begin
        int k;
        logic [8:0] w;
        for (int i = 0; i < 4; i++) begin
            data_a[i] = '0;
            ack_a[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d reset tx", i), tx_a[i], 1'b1);
            check($sformatf("u%0d reset rdy", i), rdy_a[i], 1'b1);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle(i, 1);

        // Even parity 0x55, 44-cycle frame.
        send(0, 9'h055, 1'b0, 9'h000, 1'b0);
        idle(0, 2);

        // Odd parity: 0x01 -> parity 0, 0x03 -> parity 1, sent back to back.
        send(3, 9'h001, 1'b0, 9'h000, 1'b0);
        send(3, 9'h003, 1'b0, 9'h000, 1'b0);
        idle(3, 2);

        // DIVISOR=1, two stop bits, ack held high across two frames.
        send(1, 9'h0A5, 1'b1, 9'h03C, 1'b0);
        send(1, 9'h03C, 1'b0, 9'h000, 1'b0);
        idle(1, 3);

        // Mid-frame ack and changing data must not alter or queue anything.
        send(0, 9'h05A, 1'b0, 9'h000, 1'b1);
        idle(0, 6);

        // Five data bits, mark parity.
        send(2, 9'h01F, 1'b0, 9'h000, 1'b0);
        idle(2, 2);

        // Reset during data bits aborts the frame; ack during reset is ignored.
        w = 9'h0C3;
        data_a[0] = w;
        ack_a[0]  = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            check($sformatf("u0 pre-reset t%0d tx", t), tx_a[0], model_tx(0, w, t));
            if (t == 1) ack_a[0] = 1'b0;
        end
        rst      = 1'b1;
        ack_a[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("u0 in-reset tx", tx_a[0], 1'b1);
            check("u0 in-reset rdy", rdy_a[0], 1'b1);
        end
        rst      = 1'b0;
        ack_a[0] = 1'b0;
        idle(0, 2);
        send(0, 9'h000, 1'b0, 9'h000, 1'b0);
        idle(0, 1);

        // Random words on random units, random gaps and mid-frame disturbances.
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(3, 0));
            w = 9'($urandom);
            idle(k, int'($urandom_range(3, 0)));
            send(k, w, 1'b0, 9'h000, bit'($urandom_range(1, 0)));
        end
        for (int i = 0; i < 4; i++) idle(i, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_tx_phy.md
# serial_tx_phy

Synthesizable line-level serial transmitter. It accepts words over the same `data`/`rdy`/`ack` handshake the simulated `serial_tx` model exposes and drives an asynchronous serial line (`tx`). It sits between the SoC's UART peripheral core and the board pin, replacing the simulation model in hardware builds. It is the transmitting end of the line that a serial receiver (`serial_rx` on the other side) samples.

## Interface
- `DATA_BITS`, 8: word width, 5..9.
- `DIVISOR`, 16: clock cycles per line bit, ≥1.
- `PARITY`, "none": one of "none", "even", "odd", "mark", "space".
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  DATA_BITS  word to send; sampled only on accept.
- `ack`  in  1  producer strobe; a word is accepted on a cycle with `rdy & ack`.
- `rdy`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial line, idle high.

## Operation
- Frame format, in order:
  - start bit (0);
  - `DATA_BITS` data bits, LSB first;
  - parity bit, if `PARITY` is not "none";
  - `STOP_BITS` stop bits (1).
- Parity bit value:
  - even: XOR of the data bits;
  - odd: its complement;
  - mark: 1;
  - space: 0.
- Parity is computed from the word latched at accept. Later changes on `data` have no effect.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after one bit time.
  - DATA → PARITY, or → STOP if there is no parity, after the `DATA_BITS`-th bit.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after the last stop bit.
  - STOP → START directly if an accept happens in the final cycle of the last stop bit.
- Bit timing: a cycle counter counts 0..`DIVISOR`-1. Each line bit is held exactly `DIVISOR` cycles. The counter width is max(1, clog2(`DIVISOR`)).
- A bit index counter runs 0..`DATA_BITS`-1 in DATA and 0..`STOP_BITS`-1 in STOP.
- A shift register loads `data` on accept and shifts right once per data bit. `tx` is driven from a register and is glitch-free.
- `rdy` is high in these cases only:
  - in IDLE;
  - in the final cycle of the final stop bit.
- `rdy` is low in every other cycle. `ack` while `rdy` is low is ignored: no queuing, no error.
- Reset behaviour:
  - While `rst` is high: state = IDLE, `tx` = 1, `rdy` = 1, and `ack` is ignored.
  - Reset mid-frame aborts the frame immediately. `tx` returns to 1 on the cycle after the `rst` edge, and a truncated frame is permitted on the line.

## Timing
- Let F = (1 + `DATA_BITS` + P + `STOP_BITS`) × `DIVISOR`, where P = 1 if parity is enabled, else 0.
- Accept at cycle N:
  - `tx` = 0 during cycles N+1 .. N+`DIVISOR`;
  - data bit k occupies cycles N+1+(k+1)·`DIVISOR` .. N+(k+2)·`DIVISOR`;
  - `rdy` = 0 from N+1 through N+F-1;
  - `rdy` = 1 at cycle N+F, which is the last stop-bit cycle.
- Back-to-back accepts sustain one frame every F cycles with no idle gap between frames.
- `DIVISOR` = 1: every bit lasts one cycle. `rdy` is high in the single stop-bit cycle (when `STOP_BITS` = 1).
- Latency from accept to the start-bit edge is 1 cycle.

## Structure
- Shared package/include holds:
  - the state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - the parity-mode constants;
  - a parity function, reused by the future hardware receiver.
- Sub-module `serial_baud_strobe`:
  - holds the `DIVISOR` counter;
  - outputs `bit_end`, high in the last cycle of each bit;
  - has a `restart` input, pulsed on accept.
- The top module holds the FSM, the shift register and the bit index.

## Test plan
- `DATA_BITS`=8, `DIVISOR`=4, even parity, 1 stop; send 0x55 -> `tx` holds each value 4 cycles in the sequence 0, 1,0,1,0,1,0,1,0, 0, 1; frame is 44 cycles; `rdy` is high only in cycle 44.
- Same configuration, odd parity; send 0x01 -> parity bit = 0; send 0x03 -> parity bit = 1.
- `DIVISOR`=1, no parity, 2 stop bits; hold `ack` high and offer 0xA5 then 0x3C -> two 11-cycle frames with no gap; second frame's start bit appears on the cycle after the first frame's final stop-bit cycle; data bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- `ack` pulsed mid-frame with `data`=0xFF, then `data` changed during the frame -> only the originally accepted word is transmitted; no extra frame follows.
- `rst` asserted during the data bits -> next cycle `tx`=1 and `rdy`=1; after release, an accept of 0x00 yields a clean full frame.
- `DATA_BITS`=5, mark parity, 1 stop, `DIVISOR`=3; send 0x1F -> 8-bit frame (24 cycles) with parity bit 1; the upper `data` bits are never driven.
